// File: rtl/tcp_misc_pkg.sv
// tcp_misc_pkg: shared TCP header, slow-path send-queue entry types and defaults
package tcp_misc_pkg;
  localparam int FLOWID_W = 8;
  localparam int IP_ADDR_W = 32;
  localparam int SLOW_PATH_SENDQ_DEPTH = 8;
  typedef struct packed {
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [7:0]  flags;
    logic [15:0] window;
  } tcp_pkt_hdr;
  typedef struct packed {
    tcp_pkt_hdr            pkt;
    logic [FLOWID_W-1:0]   flowid;
    logic [IP_ADDR_W-1:0]  src_ip;
    logic [IP_ADDR_W-1:0]  dst_ip;
  } slow_path_sendq_entry_struct;
endpackage

// File: rtl/slow_path_sendq_out_buf.sv
// slow_path_sendq_out_buf: 2-entry flow-through skid buffer; credit says another RAM read may issue
module slow_path_sendq_out_buf
  import tcp_misc_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_val,
  input  slow_path_sendq_entry_struct in_data,
  output logic                        in_rdy,
  output logic                        credit,
  output logic                        out_val,
  output slow_path_sendq_entry_struct out_data,
  input  logic                        out_rdy
);
  logic [1:0] cnt;
  slow_path_sendq_entry_struct e0, e1;
  logic push, pop;
  assign in_rdy = cnt != 2'd2;
  assign credit = (cnt + {1'b0, in_val}) < 2'd2;
  assign out_val = cnt != 2'd0 || in_val;
  assign out_data = cnt != 2'd0 ? e0 : in_data;
  assign pop = out_rdy && cnt != 2'd0;
  // an empty buffer with a ready consumer passes the read straight through
  assign push = in_val && in_rdy && !(cnt == 2'd0 && out_rdy);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 2'd0;
      e0 <= '0;
      e1 <= '0;
    end else begin
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
      if (pop || (push && cnt == 2'd0)) e0 <= cnt == 2'd2 ? e1 : in_data;
      if (push && cnt == 2'd1 && !pop) e1 <= in_data;
    end
  end
endmodule

// File: rtl/tcp_slow_path_send_q.sv
// tcp_slow_path_send_q: in-order slow-path header request queue (RAM + skid output)
// Optional SLOW_PATH_SENDQ_DUP_DROP_EN: drop enqueues duplicating the last still-queued entry
module tcp_slow_path_send_q
  import tcp_misc_pkg::*;
#(
  parameter int DEPTH = SLOW_PATH_SENDQ_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 slow_path_send_pkt_enqueue_val,
  input  tcp_pkt_hdr           slow_path_send_pkt_enqueue_pkt,
  input  logic [FLOWID_W-1:0]  slow_path_send_pkt_enqueue_flowid,
  input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_src_ip,
  input  logic [IP_ADDR_W-1:0] slow_path_send_pkt_enqueue_dst_ip,
  output logic                 slow_path_send_pkt_enqueue_rdy,
  output logic                 slow_path_send_pkt_dequeue_val,
  output tcp_pkt_hdr           slow_path_send_pkt_dequeue_pkt,
  output logic [FLOWID_W-1:0]  slow_path_send_pkt_dequeue_flowid,
  output logic [IP_ADDR_W-1:0] slow_path_send_pkt_dequeue_src_ip,
  output logic [IP_ADDR_W-1:0] slow_path_send_pkt_dequeue_dst_ip,
  input  logic                 slow_path_send_pkt_dequeue_rdy,
  output logic [15:0]          sendq_dup_drop_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  slow_path_sendq_entry_struct mem [DEPTH];
  slow_path_sendq_entry_struct enq_entry, rd_data, deq_entry;
  logic [PTR_W:0] wr_ptr, rd_ptr, iss_ptr;
  logic enq_fire, deq_fire, wr_en, issue, rd_val, buf_in_rdy, credit;
  assign enq_entry = {slow_path_send_pkt_enqueue_pkt, slow_path_send_pkt_enqueue_flowid,
                      slow_path_send_pkt_enqueue_src_ip, slow_path_send_pkt_enqueue_dst_ip};
  // rd_ptr retires on dequeue, so occupancy covers entries sitting in the output stage too
  assign slow_path_send_pkt_enqueue_rdy = (wr_ptr - rd_ptr) != (PTR_W+1)'(DEPTH);
  assign enq_fire = slow_path_send_pkt_enqueue_val && slow_path_send_pkt_enqueue_rdy;
  assign deq_fire = slow_path_send_pkt_dequeue_val && slow_path_send_pkt_dequeue_rdy;
  assign issue = wr_ptr != iss_ptr && credit;
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= enq_entry;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      iss_ptr <= '0;
      rd_val <= 1'b0;
      rd_data <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (deq_fire) rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      if (issue) begin
        iss_ptr <= iss_ptr + (PTR_W+1)'(1);
        rd_data <= mem[iss_ptr[PTR_W-1:0]];
      end
      rd_val <= issue || (rd_val && !buf_in_rdy);
    end
  end
  slow_path_sendq_out_buf u_out_buf (
    .clk     (clk),
    .rst     (rst),
    .in_val  (rd_val),
    .in_data (rd_data),
    .in_rdy  (buf_in_rdy),
    .credit  (credit),
    .out_val (slow_path_send_pkt_dequeue_val),
    .out_data(deq_entry),
    .out_rdy (slow_path_send_pkt_dequeue_rdy)
  );
  assign {slow_path_send_pkt_dequeue_pkt, slow_path_send_pkt_dequeue_flowid,
          slow_path_send_pkt_dequeue_src_ip, slow_path_send_pkt_dequeue_dst_ip} = deq_entry;
`ifdef SLOW_PATH_SENDQ_DUP_DROP_EN
  logic [FLOWID_W+71:0] key, last_key;
  logic [PTR_W:0] last_ptr;
  logic last_val, last_leaving, dup;
  logic [15:0] drop_cnt;
  assign key = {slow_path_send_pkt_enqueue_flowid, slow_path_send_pkt_enqueue_pkt.seq_num,
                slow_path_send_pkt_enqueue_pkt.ack_num, slow_path_send_pkt_enqueue_pkt.flags};
  assign last_leaving = deq_fire && rd_ptr == last_ptr;
  assign dup = last_val && !last_leaving && key == last_key;
  assign wr_en = enq_fire && !dup;
  assign sendq_dup_drop_cnt = drop_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      last_val <= 1'b0;
      last_key <= '0;
      last_ptr <= '0;
      drop_cnt <= 16'd0;
    end else begin
      if (wr_en) begin
        last_val <= 1'b1;
        last_key <= key;
        last_ptr <= wr_ptr;
      end else if (last_leaving) last_val <= 1'b0;
      if (enq_fire && dup && drop_cnt != 16'hffff) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`else
  assign wr_en = enq_fire;
  assign sendq_dup_drop_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_tcp_slow_path_send_q.sv
// tb_tcp_slow_path_send_q: scoreboard bench for the slow-path send queue
module tb_tcp_slow_path_send_q;
  import tcp_misc_pkg::*;
  localparam int CW = $bits(slow_path_sendq_entry_struct);
  logic clk = 1'b0, rst = 1'b1;
  logic enq_val = 1'b0, enq_rdy, deq_val, deq_rdy = 1'b0;
  tcp_pkt_hdr enq_pkt = '0, deq_pkt;
  logic [FLOWID_W-1:0] enq_flowid = '0, deq_flowid;
  logic [IP_ADDR_W-1:0] enq_src_ip = '0, enq_dst_ip = '0, deq_src_ip, deq_dst_ip;
  logic [15:0] drop_cnt;
  slow_path_sendq_entry_struct deq_e, prev_e, sb[$];
  logic prev_stall = 1'b0;
  int passed = 0, total = 0, deq_count = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  tcp_slow_path_send_q dut (
    .clk(clk), .rst(rst),
    .slow_path_send_pkt_enqueue_val(enq_val),
    .slow_path_send_pkt_enqueue_pkt(enq_pkt),
    .slow_path_send_pkt_enqueue_flowid(enq_flowid),
    .slow_path_send_pkt_enqueue_src_ip(enq_src_ip),
    .slow_path_send_pkt_enqueue_dst_ip(enq_dst_ip),
    .slow_path_send_pkt_enqueue_rdy(enq_rdy),
    .slow_path_send_pkt_dequeue_val(deq_val),
    .slow_path_send_pkt_dequeue_pkt(deq_pkt),
    .slow_path_send_pkt_dequeue_flowid(deq_flowid),
    .slow_path_send_pkt_dequeue_src_ip(deq_src_ip),
    .slow_path_send_pkt_dequeue_dst_ip(deq_dst_ip),
    .slow_path_send_pkt_dequeue_rdy(deq_rdy),
    .sendq_dup_drop_cnt(drop_cnt)
  );
  assign deq_e = {deq_pkt, deq_flowid, deq_src_ip, deq_dst_ip};
  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic slow_path_sendq_entry_struct mk(input logic [7:0] fid, input logic [31:0] seq,
                                                     input logic [31:0] ack);
    slow_path_sendq_entry_struct e;
    e.pkt.src_port = 16'($urandom);
    e.pkt.dst_port = 16'($urandom);
    e.pkt.seq_num = seq;
    e.pkt.ack_num = ack;
    e.pkt.flags = 8'h12;
    e.pkt.window = 16'($urandom);
    e.flowid = fid;
    e.src_ip = $urandom;
    e.dst_ip = $urandom;
    return e;
  endfunction
  function automatic slow_path_sendq_entry_struct rnd();
    return mk(8'($urandom), $urandom, $urandom);
  endfunction
  task automatic drive(input slow_path_sendq_entry_struct e);
    enq_val = 1'b1;
    {enq_pkt, enq_flowid, enq_src_ip, enq_dst_ip} = e;
  endtask
  // called and returns at posedge+1; accepted entries are pushed to the scoreboard if expect_write
  task automatic enq(input slow_path_sendq_entry_struct e, input bit expect_write);
    int n = 0;
    drive(e);
    @(negedge clk);
    while (!enq_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("enq_accept", CW'(enq_rdy), CW'(1));
    if (expect_write) sb.push_back(e);
    @(posedge clk);
    #1 enq_val = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    deq_rdy = 1'b1;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", CW'(sb.size()), CW'(0));
    @(negedge clk);
    check("drain_idle_val", CW'(deq_val), CW'(0));
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (rst) prev_stall <= 1'b0;
    else begin
      if (prev_stall) begin
        check("hold_val", CW'(deq_val), CW'(1));
        check("hold_data", CW'(deq_e), CW'(prev_e));
      end
      if (deq_val && deq_rdy) begin
        check("deq_expected", CW'(sb.size() != 0), CW'(1));
        if (sb.size() != 0) check("deq_data", CW'(deq_e), CW'(sb.pop_front()));
        deq_count <= deq_count + 1;
      end
      prev_stall <= deq_val && !deq_rdy;
      prev_e <= deq_e;
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    slow_path_sendq_entry_struct e, e9;
    bit done;
    int d0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_enq_rdy", CW'(enq_rdy), CW'(1));
    check("rst_deq_val", CW'(deq_val), CW'(0));
    check("rst_deq_data", CW'(deq_e), CW'(0));
    check("rst_drop_cnt", CW'(drop_cnt), CW'(0));
    // single entry, two-cycle latency
    deq_rdy = 1'b1;
    while (cyc < 9) @(posedge clk);
    #1 enq(mk(8'd3, 32'hff, 32'h1001), 1'b1);
    @(negedge clk);
    check("lat_n1_val", CW'(deq_val), CW'(0));
    @(negedge clk);
    check("lat_n2_val", CW'(deq_val), CW'(1));
    @(negedge clk);
    check("single_after_val", CW'(deq_val), CW'(0));
    @(posedge clk);
    #1 drain();
    // fill to full with the consumer stalled
    deq_rdy = 1'b0;
    for (int i = 0; i < 8; i++) enq(rnd(), 1'b1);
    @(negedge clk);
    check("full_rdy", CW'(enq_rdy), CW'(0));
    e9 = rnd();
    drive(e9);
    repeat (3) begin
      @(negedge clk);
      check("full_held_rdy", CW'(enq_rdy), CW'(0));
    end
    @(posedge clk);
    #1 deq_rdy = 1'b1;
    @(negedge clk);
    check("full_deq_cycle_rdy", CW'(enq_rdy), CW'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rdy_after_first_deq", CW'(enq_rdy), CW'(1));
    sb.push_back(e9);
    @(posedge clk);
    #1 enq_val = 1'b0;
    drain();
    // streaming: one dequeue per cycle across pointer wraps
    d0 = deq_count;
    for (int i = 0; i < 40; i++) enq(rnd(), 1'b1);
    @(negedge clk);
    #1 check("stream_cnt_l1", CW'(deq_count - d0), CW'(39));
    @(negedge clk);
    #1 check("stream_cnt_l2", CW'(deq_count - d0), CW'(40));
    @(posedge clk);
    #1 drain();
    // random consumer back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          if ($urandom_range(3) == 0) begin
            @(posedge clk);
            #1;
          end
          enq(rnd(), 1'b1);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 deq_rdy = 1'($urandom % 2);
        end
      end
    join
    drain();
    // reset with entries queued and a RAM read in flight
    deq_rdy = 1'b0;
    for (int i = 0; i < 5; i++) enq(rnd(), 1'b1);
    deq_rdy = 1'b1;
    @(posedge clk);
    #1 deq_rdy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_deq_val", CW'(deq_val), CW'(0));
    check("mid_rst_enq_rdy", CW'(enq_rdy), CW'(1));
    check("mid_rst_deq_data", CW'(deq_e), CW'(0));
    @(posedge clk);
    #1 deq_rdy = 1'b1;
    enq(rnd(), 1'b1);
    @(negedge clk);
    check("post_rst_lat_n1", CW'(deq_val), CW'(0));
    @(negedge clk);
    check("post_rst_lat_n2", CW'(deq_val), CW'(1));
    @(posedge clk);
    #1 drain();
    // back-to-back identical SYN-ACK for flowid 5
    e = mk(8'd5, 32'h1234_5678, 32'h9abc_def0);
    deq_rdy = 1'b0;
    d0 = deq_count;
`ifdef SLOW_PATH_SENDQ_DUP_DROP_EN
    enq(e, 1'b1);
    enq(e, 1'b0);
    @(negedge clk);
    check("dup_drop_cnt", CW'(drop_cnt), CW'(1));
    @(posedge clk);
    #1 drain();
    check("dup_one_deq", CW'(deq_count - d0), CW'(1));
    enq(e, 1'b1);
    drain();
    check("dup_requeue_cnt", CW'(drop_cnt), CW'(1));
    check("dup_requeue_deq", CW'(deq_count - d0), CW'(2));
`else
    enq(e, 1'b1);
    enq(e, 1'b1);
    @(negedge clk);
    check("nodup_drop_cnt", CW'(drop_cnt), CW'(0));
    @(posedge clk);
    #1 drain();
    check("nodup_two_deq", CW'(deq_count - d0), CW'(2));
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
